// File: rtl/pipeline_hazard_controller_if.sv
// pipeline_hazard_controller_if: hazard inputs from the decode/execute/memory stages
// and the advance/hold/flush controls plus debug counters returned to the pipeline.
interface pipeline_hazard_controller_if #(
   parameter int CNT_WIDTH = 16
);
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic id_uses_rt;
   logic id_jump;
   logic ex_mem_read;
   logic [4:0] ex_write_reg;
   logic ex_jr;
   logic mem_pcsrc;
   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic id_ex_bubble;
   logic ex_mem_flush;
   logic [CNT_WIDTH-1:0] stall_count;
   logic [CNT_WIDTH-1:0] flush_count;
   modport master (
      output id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_write_reg, ex_jr, mem_pcsrc,
      input pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, stall_count, flush_count
   );
   modport slave (
      input id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_write_reg, ex_jr, mem_pcsrc,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: decides PC / IF-ID advance, hold or flush and ID-EX / EX-MEM bubbles
// for load-use stalls, ID jumps, EX jr and MEM-resolved branches, with saturating debug counters.
module pipeline_hazard_controller #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_WIDTH = 16
) (
   input logic clk,
   input logic reset,
   pipeline_hazard_controller_if.slave hz
);
   localparam logic [0:0] RUN = 1'b0, LSTALL = 1'b1;
   localparam logic [2:0] RELOAD = 3'(LOAD_STALL_CYCLES - 1);
   logic [0:0] state;
   logic [2:0] scnt;
   logic [CNT_WIDTH-1:0] stallCnt, flushCnt;
   logic loadUse, kill, stall, jump, redirect;
   always_comb begin
      loadUse = hz.ex_mem_read && hz.ex_write_reg != 5'd0 &&
                (hz.ex_write_reg == hz.id_rs || (hz.id_uses_rt && hz.ex_write_reg == hz.id_rt));
      kill = hz.mem_pcsrc || hz.ex_jr;
      stall = !kill && (loadUse || state == LSTALL);
      jump = !kill && !stall && hz.id_jump;
      redirect = kill || jump;
   end
   // reset forces every register to load a NOP and the PC to take its reset value
   assign hz.pc_write = reset || !stall;
   assign hz.if_id_write = reset || !stall;
   assign hz.if_id_flush = reset || redirect;
   assign hz.id_ex_bubble = reset || kill || stall;
   assign hz.ex_mem_flush = reset || hz.mem_pcsrc;
   assign hz.stall_count = stallCnt;
   assign hz.flush_count = flushCnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         scnt <= '0;
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (kill) begin
            state <= RUN;
            scnt <= '0;
         end else if (state == LSTALL) begin
            state <= (scnt == 3'd1) ? RUN : LSTALL;
            scnt <= scnt - 3'd1;
         end else if (loadUse && LOAD_STALL_CYCLES > 1) begin
            state <= LSTALL;
            scnt <= RELOAD;
         end
         if (stall && stallCnt != '1) stallCnt <= stallCnt + CNT_WIDTH'(1);
         if (redirect && flushCnt != '1) flushCnt <= flushCnt + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: drives a 1-cycle/4-bit-counter and a 3-cycle/16-bit-counter
// controller with identical stimulus and scoreboards both against a cycle model.
module tb_pipeline_hazard_controller;
   typedef struct packed {
      logic r;
      logic [4:0] rs;
      logic [4:0] rt;
      logic ur;
      logic jp;
      logic mr;
      logic [4:0] wr;
      logic jr;
      logic ps;
   } stim_t;
   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, stall_count, flush_count}
   typedef logic [36:0] exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   stim_t cur;
   logic rst;
   assign rst = cur.r;

   pipeline_hazard_controller_if #(.CNT_WIDTH(4)) hzA ();
   pipeline_hazard_controller_if #(.CNT_WIDTH(16)) hzB ();

   always_comb begin
      hzA.id_rs = cur.rs;         hzB.id_rs = cur.rs;
      hzA.id_rt = cur.rt;         hzB.id_rt = cur.rt;
      hzA.id_uses_rt = cur.ur;    hzB.id_uses_rt = cur.ur;
      hzA.id_jump = cur.jp;       hzB.id_jump = cur.jp;
      hzA.ex_mem_read = cur.mr;   hzB.ex_mem_read = cur.mr;
      hzA.ex_write_reg = cur.wr;  hzB.ex_write_reg = cur.wr;
      hzA.ex_jr = cur.jr;         hzB.ex_jr = cur.jr;
      hzA.mem_pcsrc = cur.ps;     hzB.mem_pcsrc = cur.ps;
   end

   pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .CNT_WIDTH(4)) dutA (.clk(clk), .reset(rst), .hz(hzA));
   pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .CNT_WIDTH(16)) dutB (.clk(clk), .reset(rst), .hz(hzB));

   exp_t actA, actB;
   assign actA = {hzA.pc_write, hzA.if_id_write, hzA.if_id_flush, hzA.id_ex_bubble, hzA.ex_mem_flush,
                  12'd0, hzA.stall_count, 12'd0, hzA.flush_count};
   assign actB = {hzB.pc_write, hzB.if_id_write, hzB.if_id_flush, hzB.id_ex_bubble, hzB.ex_mem_flush,
                  hzB.stall_count, hzB.flush_count};

   exp_t qA[$], qB[$];
   exp_t eA, eB;
   int checks = 0, passed = 0;
   int remA = 0, scA = 0, fcA = 0, nremA = 0, nscA = 0, nfcA = 0;
   int remB = 0, scB = 0, fcB = 0, nremB = 0, nscB = 0, nfcB = 0;

   // rem = forced stall cycles still owed after the current one
   function automatic void model(input stim_t s, input int lsc, input int cw, input int rem,
                                 input int sc, input int fc, output exp_t e,
                                 output int nrem, output int nsc, output int nfc);
      int sat;
      logic lu;
      logic [4:0] o;
      sat = (1 << cw) - 1;
      lu = s.mr && s.wr != 5'd0 && (s.wr == s.rs || (s.ur && s.wr == s.rt));
      nrem = rem; nsc = sc; nfc = fc;
      if (s.r) begin
         o = 5'b11111; nrem = 0; nsc = 0; nfc = 0;
      end else if (s.ps) begin
         o = 5'b11111; nrem = 0; nfc = (fc < sat) ? fc + 1 : fc;
      end else if (s.jr) begin
         o = 5'b11110; nrem = 0; nfc = (fc < sat) ? fc + 1 : fc;
      end else if (rem > 0 || lu) begin
         o = 5'b00010; nrem = (rem > 0) ? rem - 1 : lsc - 1; nsc = (sc < sat) ? sc + 1 : sc;
      end else if (s.jp) begin
         o = 5'b11100; nfc = (fc < sat) ? fc + 1 : fc;
      end else begin
         o = 5'b11000;
      end
      e = {o, 16'(sc), 16'(fc)};
   endfunction

   task automatic drive(input stim_t s);
      exp_t e;
      @(negedge clk);
      remA = nremA; scA = nscA; fcA = nfcA;
      remB = nremB; scB = nscB; fcB = nfcB;
      cur = s;
      #1;
      model(s, 1, 4, remA, scA, fcA, e, nremA, nscA, nfcA);
      qA.push_back(e);
      model(s, 3, 16, remB, scB, fcB, e, nremB, nscB, nfcB);
      qB.push_back(e);
   endtask

   //                         r  rs rt ur jp mr wr jr ps
   localparam stim_t IDLE  = '{0, 1, 2, 1, 0, 0, 0, 0, 0};
   localparam stim_t RST   = '{1, 8, 9, 1, 1, 1, 8, 0, 0};
   localparam stim_t LURS  = '{0, 8, 9, 1, 0, 1, 8, 0, 0};
   localparam stim_t LURT  = '{0, 3, 8, 1, 0, 1, 8, 0, 0};
   localparam stim_t NORT  = '{0, 3, 8, 0, 0, 1, 8, 0, 0};
   localparam stim_t LWZ   = '{0, 0, 0, 1, 0, 1, 0, 0, 0};
   localparam stim_t BR    = '{0, 1, 2, 1, 0, 0, 0, 0, 1};
   localparam stim_t LUBR  = '{0, 8, 9, 1, 0, 1, 8, 0, 1};
   localparam stim_t JMP   = '{0, 1, 2, 0, 1, 0, 0, 0, 0};
   localparam stim_t JR    = '{0, 1, 2, 1, 0, 0, 0, 1, 0};
   localparam stim_t LUJMP = '{0, 8, 9, 0, 1, 1, 8, 0, 0};

   task automatic test_reset();
      stim_t t[3] = '{RST, RST, IDLE};
      foreach (t[i]) begin
         drive(t[i]);
         eA = qA.pop_front(); eB = qB.pop_front(); checks += 2;
         if (actA !== eA) $display("FAIL reset[%0d] dutA got %h want %h", i, actA, eA); else passed++;
         if (actB !== eB) $display("FAIL reset[%0d] dutB got %h want %h", i, actB, eB); else passed++;
      end
   endtask

   task automatic test_load_use();
      stim_t t[13] = '{LURS, IDLE, IDLE, IDLE, LURT, IDLE, IDLE, IDLE, NORT, IDLE, LWZ, LWZ, IDLE};
      foreach (t[i]) begin
         drive(t[i]);
         eA = qA.pop_front(); eB = qB.pop_front(); checks += 2;
         if (actA !== eA) $display("FAIL load_use[%0d] dutA got %h want %h", i, actA, eA); else passed++;
         if (actB !== eB) $display("FAIL load_use[%0d] dutB got %h want %h", i, actB, eB); else passed++;
      end
   endtask

   task automatic test_branch();
      stim_t t[3] = '{BR, IDLE, IDLE};
      foreach (t[i]) begin
         drive(t[i]);
         eA = qA.pop_front(); eB = qB.pop_front(); checks += 2;
         if (actA !== eA) $display("FAIL branch[%0d] dutA got %h want %h", i, actA, eA); else passed++;
         if (actB !== eB) $display("FAIL branch[%0d] dutB got %h want %h", i, actB, eB); else passed++;
      end
   endtask

   task automatic test_simultaneous();
      stim_t t[7] = '{LUBR, IDLE, LURS, IDLE, BR, IDLE, IDLE};
      foreach (t[i]) begin
         drive(t[i]);
         eA = qA.pop_front(); eB = qB.pop_front(); checks += 2;
         if (actA !== eA) $display("FAIL simultaneous[%0d] dutA got %h want %h", i, actA, eA); else passed++;
         if (actB !== eB) $display("FAIL simultaneous[%0d] dutB got %h want %h", i, actB, eB); else passed++;
      end
   endtask

   task automatic test_jump();
      stim_t t[9] = '{JMP, IDLE, JR, IDLE, LUJMP, JMP, JMP, LURS, JR};
      foreach (t[i]) begin
         drive(t[i]);
         eA = qA.pop_front(); eB = qB.pop_front(); checks += 2;
         if (actA !== eA) $display("FAIL jump[%0d] dutA got %h want %h", i, actA, eA); else passed++;
         if (actB !== eB) $display("FAIL jump[%0d] dutB got %h want %h", i, actB, eB); else passed++;
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 44; i++) begin
         drive(i < 20 ? LURS : (i < 42 ? JMP : IDLE));
         eA = qA.pop_front(); eB = qB.pop_front(); checks += 2;
         if (actA !== eA) $display("FAIL saturation[%0d] dutA got %h want %h", i, actA, eA); else passed++;
         if (actB !== eB) $display("FAIL saturation[%0d] dutB got %h want %h", i, actB, eB); else passed++;
      end
   endtask

   task automatic test_reset_mid_stall();
      stim_t t[7] = '{LURS, IDLE, RST, IDLE, IDLE, LURS, IDLE};
      foreach (t[i]) begin
         drive(t[i]);
         eA = qA.pop_front(); eB = qB.pop_front(); checks += 2;
         if (actA !== eA) $display("FAIL reset_mid_stall[%0d] dutA got %h want %h", i, actA, eA); else passed++;
         if (actB !== eB) $display("FAIL reset_mid_stall[%0d] dutB got %h want %h", i, actB, eB); else passed++;
      end
   endtask

   initial begin
      cur = RST;
      test_reset();
      test_load_use();
      test_branch();
      test_simultaneous();
      test_jump();
      test_saturation();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired after %0d of %0d checks", passed, checks);
      $fatal(1);
   end
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequences the five-stage MIPS pipeline: it decides each cycle whether the PC and the IF/ID register advance, hold, or are flushed, and when bubbles are injected into ID/EX and EX/MEM. It resolves load-use hazards, jump redirects decoded in ID, and taken branches resolved in MEM. It also keeps saturating stall and flush counters for debug. It sits beside the Control unit and drives the write-enable and flush inputs of the PC register and the pipeline registers.

## Interface
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard (legal range 1..7).
- CNT_WIDTH, 16: width of each performance counter.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- id_rs  in  5  IF_ID instruction [25:21].
- id_rt  in  5  IF_ID instruction [20:16].
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, beq/bne).
- id_jump  in  1  ID instruction is j/jal.
- ex_mem_read  in  1  ID_EX MemRead.
- ex_write_reg  in  5  ID_EX destination register.
- ex_jr  in  1  JR decoded by ALUControl in EX.
- mem_pcsrc  in  1  taken branch resolved in MEM; selects the EX_MEM branch target.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_bubble  out  1  ID/EX loads zero control.
- ex_mem_flush  out  1  EX/MEM loads zero control.
- stall_count  out  CNT_WIDTH  cycles with pc_write=0.
- flush_count  out  CNT_WIDTH  redirect events (branch, jr, jump).

## Operation
- State machine states: RUN, LSTALL. The state register and the stall counter `scnt` (3 bits) are the only sequential control.
- Load-use hazard (`lu`): ex_mem_read=1 && ex_write_reg!=0 && (ex_write_reg==id_rs || (id_uses_rt && ex_write_reg==id_rt)).
- Priority in any state, highest first:
  1. mem_pcsrc.
  2. ex_jr.
  3. lu or LSTALL.
  4. id_jump.
- mem_pcsrc=1:
  - Outputs: pc_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, if_id_write=1.
  - Next state RUN; scnt cleared; flush_count+1.
- ex_jr=1 (no mem_pcsrc):
  - Outputs: pc_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=0.
  - Next state RUN; flush_count+1.
- RUN with lu=1:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If LOAD_STALL_CYCLES>1, go to LSTALL with scnt=LOAD_STALL_CYCLES-1; otherwise stay in RUN.
- LSTALL:
  - Outputs are the same as the RUN+lu case.
  - scnt decrements each cycle; the state returns to RUN in the cycle after scnt reaches 1.
  - A lu recomputed during LSTALL is ignored; stall length is fixed.
- id_jump=1 (no higher event):
  - Outputs: pc_write=1, if_id_write=1, if_id_flush=1 (squash the sequential fetch).
  - flush_count+1.
- Default: pc_write=1, if_id_write=1, all flush/bubble=0.
- A cycle can carry both a stall and a flush. The flush wins: the stall is dropped and it is not counted in stall_count.
- Counters:
  - stall_count increments on every cycle with pc_write=0.
  - flush_count increments once per redirect cycle.
  - Both saturate at 2^CNT_WIDTH-1; they do not wrap.
- ex_write_reg=0 never causes a stall.

## Timing
- All outputs are combinational from the state, scnt, and current inputs. They are valid in the same cycle as the detecting inputs and consumed at the next rising edge.
- A load-use hazard costs exactly LOAD_STALL_CYCLES cycles with pc_write=0, counting from the first detection cycle.
- Branch penalty is 3 squashed instructions; jr penalty is 2; jump penalty is 1.
- reset=1 at a rising edge:
  - state=RUN, scnt=0, stall_count=0, flush_count=0.
  - While reset is high, outputs are: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1.
- Reset mid-LSTALL abandons the stall immediately; there is no residual stall after reset is released.

## Test plan
- Load-use: EX lw to $t0 (ex_write_reg=8), ID add reading $t0 as rs, LOAD_STALL_CYCLES=1 -> exactly 1 cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count=1.
- Same as above with LOAD_STALL_CYCLES=3 -> 3 consecutive stall cycles, then RUN; stall_count=3. Also: lw to $zero -> no stall.
- Branch taken: mem_pcsrc=1 -> if_id_flush, id_ex_bubble, and ex_mem_flush all 1 for one cycle; flush_count=1.
- Simultaneous events: lu=1 and mem_pcsrc=1 in the same cycle -> flush outputs, pc_write=1, stall_count unchanged. A second case: mem_pcsrc=1 in the 2nd cycle of a 3-cycle LSTALL -> state returns to RUN next cycle.
- j in ID -> one cycle with if_id_flush=1, pc_write=1. jr in EX -> if_id_flush=1 and id_ex_bubble=1 for one cycle.
- Saturation: CNT_WIDTH=4 with 20 stall cycles -> stall_count holds at 15. Reset asserted mid-LSTALL -> counters=0 and normal flow resumes on the first cycle after reset.
